// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game-control slice: game state
// encoding, one-hot heading constants and the reversal lookup.
package snake_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        WIN   = 3'd3,
        LOSE  = 3'd4
    } game_state_t;

    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    // Heading that would reverse the snake onto its own neck. A non one-hot
    // input has no opposite, so nothing is ever rejected against it.
    function automatic logic [3:0] opposite_dir(input logic [3:0] dir);
        case (dir)
            DIR_UP:    opposite_dir = DIR_DOWN;
            DIR_DOWN:  opposite_dir = DIR_UP;
            DIR_LEFT:  opposite_dir = DIR_RIGHT;
            DIR_RIGHT: opposite_dir = DIR_LEFT;
            default:   opposite_dir = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/snake_game_ctrl_move_timer.sv
// Move-period timer: counts clock cycles while the game runs, flags the wrap
// cycle and emits a registered one-cycle move strobe after it.
// Optional build macro SNAKE_SPEEDUP_EN: the period shrinks on each growth.
module move_timer #(
    parameter int MOVE_DIV = 2500000,
    parameter int DIV_W    = 22
) (
    input  logic clk,
    input  logic nRst,
    input  logic run_en,
    input  logic start_clr,
    input  logic grow_evt,
    output logic wrap,
    output logic move_en
);

    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] last;

`ifdef SNAKE_SPEEDUP_EN
    // One extra bit so that MOVE_DIV == 2**DIV_W is still representable.
    localparam int P_W = DIV_W + 1;
    localparam logic [P_W-1:0] PERIOD_INIT = P_W'(MOVE_DIV);
    localparam logic [P_W-1:0] PERIOD_STEP = P_W'(MOVE_DIV / 16);
    localparam logic [P_W-1:0] PERIOD_MIN  = P_W'(MOVE_DIV / 4);

    logic [P_W-1:0] period_target;
    logic [P_W-1:0] period_active;

    // Shrink the target on each growth; the active period adopts it only at a wrap.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            period_target <= PERIOD_INIT;
            period_active <= PERIOD_INIT;
        end else if (start_clr) begin
            period_target <= PERIOD_INIT;
            period_active <= PERIOD_INIT;
        end else begin
            if (grow_evt) begin
                period_target <= (period_target >= PERIOD_MIN + PERIOD_STEP)
                               ? period_target - PERIOD_STEP : PERIOD_MIN;
            end
            if (wrap) begin
                period_active <= period_target;
            end
        end
    end

    assign last = DIV_W'(period_active - 1'b1);
`else
    logic unused_grow_evt;
    assign unused_grow_evt = grow_evt;
    assign last = DIV_W'(MOVE_DIV - 1);
`endif

    assign wrap = run_en && (count == last);

    // Free-running period counter; frozen outside RUN, cleared on a fresh start.
    always_ff @(posedge clk or negedge nRst) begin
        // NOTE: flops update with <= so every register samples pre-edge values;
        // blocking = here would let later statements see already-updated state.
        if (!nRst) begin
            count   <= '0;
            move_en <= 1'b0;
        end else begin
            move_en <= wrap;
            if (start_clr) begin
                count <= '0;
            end else if (run_en) begin
                count <= wrap ? '0 : count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game-control stage: top-level game FSM, committed heading with
// reversal rejection, move strobe and length tracking.
// Optional build macro SNAKE_SPEEDUP_EN (handled inside move_timer).
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int MOVE_DIV = 2500000,
    parameter int DIV_W    = 22,
    parameter int INIT_LEN = 3,
    parameter int MAX_LEN  = 64,
    parameter int LEN_W    = 7
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             goodColl,
    input  logic             badColl,
    input  logic             button,
    input  logic [3:0]       direction,
    output logic [2:0]       state,
    output logic [3:0]       heading,
    output logic             move_en,
    output logic [LEN_W-1:0] length,
    output logic             grow
);

    game_state_t state_q;
    game_state_t state_d;
    logic [3:0]  pend_q;
    logic        grew_q;
    logic        start_clr;
    logic        run_en;
    logic        grow_now;
    logic        dir_ok;
    logic        wrap;

    assign state = state_q;

    // Game state register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; in RUN a collision outranks the button.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:  if (button) state_d = RUN;
            RUN: begin
                if (badColl) begin
                    state_d = LOSE;
                end else if (grow_now && (length == LEN_W'(MAX_LEN - 1))) begin
                    state_d = WIN;
                end else if (!goodColl && button) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: if (button) state_d = RUN;
            WIN, LOSE: if (button) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control decodes feeding the timer and the datapath registers.
    always_comb begin
        start_clr = (state_q == IDLE) && button;
        run_en    = (state_q == RUN) && (state_d == RUN);
        grow_now  = (state_q == RUN) && goodColl && !badColl && !grew_q
                    && (length < LEN_W'(MAX_LEN));
        dir_ok    = (state_q == RUN) && $onehot(direction)
                    && (direction != opposite_dir(heading));
    end

    move_timer #(
        .MOVE_DIV (MOVE_DIV),
        .DIV_W    (DIV_W)
    ) u_move_timer (
        .clk       (clk),
        .nRst      (nRst),
        .run_en    (run_en),
        .start_clr (start_clr),
        .grow_evt  (grow_now),
        .wrap      (wrap),
        .move_en   (move_en)
    );

    // Heading, pending request, length and growth bookkeeping.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            heading <= DIR_RIGHT;
            pend_q  <= DIR_RIGHT;
            length  <= LEN_W'(INIT_LEN);
            grow    <= 1'b0;
            grew_q  <= 1'b0;
        end else begin
            grow <= grow_now;
            if (start_clr) begin
                heading <= DIR_RIGHT;
                pend_q  <= DIR_RIGHT;
                length  <= LEN_W'(INIT_LEN);
                grew_q  <= 1'b0;
            end else begin
                // Filter compares against the committed heading, so two quick
                // turns inside one period cannot fold the snake back on itself.
                if (dir_ok) pend_q <= direction;
                if (wrap) heading <= pend_q;
                if (grow_now) length <= length + 1'b1;
                if (wrap) begin
                    grew_q <= 1'b0;
                end else if (grow_now) begin
                    grew_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: directed scenarios followed by
// random stimulus, every cycle compared against a behavioural game model.
// Build with SNAKE_SPEEDUP_EN to exercise the shrinking move period.
module tb_snake_game_ctrl;

`ifdef SNAKE_SPEEDUP_EN
    localparam int TB_DIV  = 64;
    localparam bit SPEEDUP = 1'b1;
`else
    localparam int TB_DIV  = 8;
    localparam bit SPEEDUP = 1'b0;
`endif
    localparam int INIT_LEN = 3;
    localparam int MAX_LEN  = 5;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_WIN   = 3;
    localparam int M_LOSE  = 4;

    logic       clk;
    logic       nRst;
    logic       goodColl;
    logic       badColl;
    logic       button;
    logic [3:0] direction;
    logic [2:0] state;
    logic [3:0] heading;
    logic       move_en;
    logic [6:0] length;
    logic       grow;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model of the game, advanced once per clock edge.
    int       m_state;
    bit [3:0] m_head;
    bit [3:0] m_pend;
    int       m_len;
    bit       m_grow;
    bit       m_move;
    bit       m_grew;
    int       m_phase;
    int       m_period;
    int       m_target;

    snake_game_ctrl #(
        .MOVE_DIV (TB_DIV),
        .DIV_W    (8),
        .INIT_LEN (INIT_LEN),
        .MAX_LEN  (MAX_LEN),
        .LEN_W    (7)
    ) dut (
        .clk       (clk),
        .nRst      (nRst),
        .goodColl  (goodColl),
        .badColl   (badColl),
        .button    (button),
        .direction (direction),
        .state     (state),
        .heading   (heading),
        .move_en   (move_en),
        .length    (length),
        .grow      (grow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic bit [3:0] flip(input bit [3:0] h);
        return {h[2], h[3], h[0], h[1]};
    endfunction

    task automatic model_reset();
        m_state  = M_IDLE;
        m_head   = 4'b0001;
        m_pend   = 4'b0001;
        m_len    = INIT_LEN;
        m_grow   = 1'b0;
        m_move   = 1'b0;
        m_grew   = 1'b0;
        m_phase  = 0;
        m_period = TB_DIV;
        m_target = TB_DIV;
    endtask

    task automatic model_step(input bit b, input bit g, input bit bd, input bit [3:0] d);
        bit [3:0] head_old;
        bit [3:0] pend_old;
        int       target_old;
        head_old   = m_head;
        pend_old   = m_pend;
        target_old = m_target;
        m_grow = 1'b0;
        m_move = 1'b0;
        case (m_state)
            M_IDLE: if (b) begin
                m_state  = M_RUN;
                m_len    = INIT_LEN;
                m_head   = 4'b0001;
                m_pend   = 4'b0001;
                m_phase  = 0;
                m_grew   = 1'b0;
                m_period = TB_DIV;
                m_target = TB_DIV;
            end
            M_RUN: begin
                if ($countones(d) == 1 && d != flip(head_old)) m_pend = d;
                if (bd) begin
                    m_state = M_LOSE;
                end else if (g) begin
                    if (!m_grew) begin
                        m_len++;
                        m_grow = 1'b1;
                        m_grew = 1'b1;
                        if (SPEEDUP)
                            m_target = (m_target - TB_DIV / 16 < TB_DIV / 4)
                                     ? TB_DIV / 4 : m_target - TB_DIV / 16;
                        if (m_len == MAX_LEN) m_state = M_WIN;
                    end
                end else if (b) begin
                    m_state = M_PAUSE;
                end
                if (m_state == M_RUN) begin
                    m_phase++;
                    if (m_phase == m_period) begin
                        m_phase  = 0;
                        m_move   = 1'b1;
                        m_head   = pend_old;
                        m_grew   = 1'b0;
                        m_period = target_old;
                    end
                end
            end
            M_PAUSE: if (b) m_state = M_RUN;
            default: if (b) m_state = M_IDLE;
        endcase
    endtask

    task automatic compare_all();
        check("state",   32'(state),   32'(m_state));
        check("heading", 32'(heading), 32'(m_head));
        check("move_en", 32'(move_en), 32'(m_move));
        check("length",  32'(length),  32'(m_len));
        check("grow",    32'(grow),    32'(m_grow));
    endtask

    // One clock: drive inputs away from the edge, step the model, sample at +1.
    task automatic cycle(input bit b, input bit g, input bit bd, input bit [3:0] d);
        button    = b;
        goodColl  = g;
        badColl   = bd;
        direction = d;
        @(posedge clk);
        model_step(b, g, bd, d);
        #1;
        compare_all();
    endtask

    // Idle cycles until the DUT strobes move_en; -1 if the budget runs out.
    task automatic wait_move(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 4'b0000);
            if (move_en) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int cnt;
        bit [3:0] d;

        nRst = 1'b1;
        button = 1'b0; goodColl = 1'b0; badColl = 1'b0; direction = 4'b0000;
        model_reset();
        #2 nRst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        nRst = 1'b1;

        // Start and move cadence.
        cycle(1'b1, 1'b0, 1'b0, 4'b0000);
        check("start_state", 32'(state), 32'(M_RUN));
        check("start_len", 32'(length), 32'(INIT_LEN));
        wait_move(2 * TB_DIV, n);
        check("first_move_gap", n, TB_DIV);
        wait_move(2 * TB_DIV, n);
        check("move_period", n, TB_DIV);
        check("heading_init", 32'(heading), 32'h1);

        // Reversal rejected; last of two legal turns wins.
        cycle(1'b0, 1'b0, 1'b0, 4'b0010);
        wait_move(2 * TB_DIV, n);
        check("reverse_dropped", 32'(heading), 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 4'b1000);
        cycle(1'b0, 1'b0, 1'b0, 4'b0100);
        wait_move(2 * TB_DIV, n);
        check("gap_after_turns", n, TB_DIV - 2);
        check("last_turn_wins", 32'(heading), 32'h4);

        // Held food: one growth per period, then WIN.
        cnt = 0;
        for (int i = 0; i < 2 * TB_DIV + 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 4'b0000);
            if (grow) cnt++;
        end
        check("grow_count", cnt, 2);
        check("win_state", 32'(state), 32'(M_WIN));
        check("win_len", 32'(length), 32'(MAX_LEN));
        cnt = 0;
        for (int i = 0; i < TB_DIV + 2; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 4'b0000);
            if (move_en) cnt++;
        end
        check("win_no_move", cnt, 0);
        cycle(1'b1, 1'b0, 1'b0, 4'b0000);
        check("win_to_idle", 32'(state), 32'(M_IDLE));

        // Bad collision wins over food in the same cycle.
        cycle(1'b1, 1'b0, 1'b0, 4'b0000);
        cycle(1'b0, 1'b1, 1'b1, 4'b0000);
        check("lose_state", 32'(state), 32'(M_LOSE));
        check("lose_len", 32'(length), 32'(INIT_LEN));
        cycle(1'b1, 1'b0, 1'b0, 4'b0000);
        check("lose_to_idle", 32'(state), 32'(M_IDLE));

        // Pause at counter 5, resume without clearing.
        cycle(1'b1, 1'b0, 1'b0, 4'b0000);
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 4'b0000);
        cycle(1'b1, 1'b0, 1'b0, 4'b0000);
        check("pause_state", 32'(state), 32'(M_PAUSE));
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 4'b1000);
            if (move_en) cnt++;
        end
        check("pause_no_move", cnt, 0);
        check("pause_held", 32'(state), 32'(M_PAUSE));
        cycle(1'b1, 1'b0, 1'b0, 4'b0000);
        check("resume_state", 32'(state), 32'(M_RUN));
        wait_move(2 * TB_DIV, n);
        check("resume_gap", n, TB_DIV - 5);

        // Period after one growth (shorter only with speedup).
        cycle(1'b0, 1'b0, 1'b1, 4'b0000);
        cycle(1'b1, 1'b0, 1'b0, 4'b0000);
        cycle(1'b1, 1'b0, 1'b0, 4'b0000);
        cycle(1'b0, 1'b1, 1'b0, 4'b0000);
        wait_move(2 * TB_DIV, n);
        check("gap_grow_period", n, TB_DIV - 1);
        wait_move(2 * TB_DIV, n);
        check("period_after_grow", n, SPEEDUP ? TB_DIV - TB_DIV / 16 : TB_DIV);

        // Asynchronous reset between edges, mid-RUN.
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 4'b1000);
        #2 nRst = 1'b0;
        #1;
        model_reset();
        check("arst_state", 32'(state), 32'(M_IDLE));
        check("arst_heading", 32'(heading), 32'h1);
        check("arst_move_en", 32'(move_en), 32'h0);
        check("arst_length", 32'(length), 32'(INIT_LEN));
        check("arst_grow", 32'(grow), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        compare_all();
        nRst = 1'b1;

        // Random play against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) d = 4'($urandom_range(0, 15));
            else d = 4'b0001 << $urandom_range(0, 3);
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 60) == 0, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
- Game-control stage directly downstream of the input edge-detect stage.
- Consumes its outputs:
  - goodColl and badColl, which are level-like;
  - button, a one-cycle rising-edge pulse;
  - direction, a one-hot level.
- Runs the top-level game FSM, holds the committed heading with reversal rejection, generates the periodic move strobe and tracks snake length for the body/render stages.

Parameters:
- MOVE_DIV, 2500000, clock cycles per move step in RUN.
- DIV_W, 22, width of the move-period counter; must satisfy MOVE_DIV <= 2**DIV_W.
- INIT_LEN, 3, snake length loaded when a game starts.
- MAX_LEN, 64, length at which the game is won.
- LEN_W, 7, width of the length output; must satisfy MAX_LEN < 2**LEN_W.

Ports:
- clk  in  1  system clock; single clock domain.
- nRst  in  1  asynchronous active-low reset; all flops clear immediately on assertion.
- goodColl  in  1  head-on-food indication; may stay high for several cycles.
- badColl  in  1  head-on-wall/body indication; may stay high for several cycles.
- button  in  1  one-cycle start/pause pulse.
- direction  in  4  one-hot requested heading: [3]=UP, [2]=DOWN, [1]=LEFT, [0]=RIGHT.
- state  out  3  current game_state_t.
- heading  out  4  committed one-hot heading, same encoding as direction.
- move_en  out  1  one-cycle strobe; the snake advances one cell.
- length  out  LEN_W  current snake length.
- grow  out  1  one-cycle pulse on each accepted growth.

Behaviour:
- Reset values:
  - state=IDLE, heading=RIGHT (4'b0001), move_en=0, length=INIT_LEN, grow=0;
  - counter=0, pending heading=RIGHT, grew flag=0.
- States: IDLE=0, RUN=1, PAUSE=2, WIN=3, LOSE=4. All outputs are registered, one-cycle latency from the inputs.
- IDLE:
  - button -> RUN;
  - on entry to RUN: length=INIT_LEN, heading=pending=RIGHT, counter=0, grew=0.
- RUN:
  - counter increments each cycle; at MOVE_DIV-1 it wraps to 0 and move_en pulses the following cycle;
  - heading <= pending on the same cycle the wrap occurs.
- RUN, input handling:
  - button -> PAUSE;
  - badColl -> LOSE, with priority over goodColl and button in the same cycle;
  - goodColl with grew=0:
    - length+1, grow pulse, grew=1;
    - if the new length equals MAX_LEN -> WIN that same transition.
  - grew clears on each wrap, so there is at most one growth per move period regardless of how long goodColl stays high.
- PAUSE:
  - counter and heading frozen; collisions and direction are ignored;
  - button -> RUN, with the counter resumed, not cleared.
- WIN/LOSE:
  - everything is held and move_en=0;
  - button -> IDLE;
  - length is kept until the next start.
- Direction filter, RUN only:
  - a request is accepted into pending only if exactly one bit is set and it is not the opposite of the committed heading;
  - same-as-heading requests are harmless;
  - the last accepted request within a move period wins;
  - opposite and multi-hot requests are dropped silently.
  - Comparing against the committed heading, not pending, prevents a two-turn self-reversal within one period.
- Simultaneous button and collision in RUN: the collision rule applies (LOSE for badColl); button is ignored that cycle.
- length never exceeds MAX_LEN and never wraps.

Optional Feature:
- Macro: SNAKE_SPEEDUP_EN.
- With it defined:
  - an internal period register starts at MOVE_DIV on entry to RUN;
  - each grow subtracts MOVE_DIV/16, floored at MOVE_DIV/4;
  - the counter wraps at period-1, and a new period takes effect from the next wrap.
- Without it: the period is the constant MOVE_DIV and no period register exists.

Decomposition:
- Shared package snake_pkg:
  - game_state_t enum;
  - DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT 4-bit constants;
  - function opposite_dir(dir).
- One natural sub-module, move_timer: counter, wrap and move_en generation, plus the speedup period when enabled. It is driven by run_en and start_clr from the FSM.

Test Plan (MOVE_DIV=8, INIT_LEN=3, MAX_LEN=5 for the bench):
1. Reset, then button pulse:
   - state=RUN and length=3 one cycle later;
   - move_en every 8 cycles; first pulse 8 cycles after RUN entry;
   - heading=0001.
2. RUN heading=0001: apply direction=0010 (LEFT) -> heading stays 0001. Then 1000, then 0100 in the same period -> heading=0100 at the next wrap.
3. goodColl held high for 20 cycles:
   - length 3->4->5 with exactly one grow per move period;
   - state=WIN after reaching 5;
   - move_en stops.
4. badColl and goodColl high in the same cycle -> state=LOSE, length unchanged. Then button -> IDLE.
5. Button in RUN at counter=5 -> PAUSE with move_en=0 for 30 cycles. Button again -> the next move_en arrives 3 cycles after resume.
6. nRst asserted mid-RUN, asynchronously between clock edges -> outputs immediately at reset values. With SNAKE_SPEEDUP_EN and MOVE_DIV=64: after one growth the move_en interval becomes 60.
